// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the execute-stage ALU decode and the iterative M-extension unit.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_RSV = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift/add) and restoring divide on operand magnitudes, one bit per step.
// hi_q/lo_q hold {product} for multiplies and {remainder, quotient} for divides.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            last_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

  logic [2:0]      f3_q;
  logic            neg_q;
  logic            rneg_q;
  logic            div0_q;
  logic            ovf_q;
  logic [XLEN-1:0] opr_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            st_div;
  logic            st_sgn1;
  logic            st_sgn2;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  // Signedness of each operand as selected by funct3 at start.
  always_comb begin
    st_div  = funct3_i[2];
    st_sgn1 = st_div ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
    st_sgn2 = st_div ? !funct3_i[0] : !funct3_i[1];
    a_neg   = st_sgn1 && src1_i[XLEN-1];
    b_neg   = st_sgn2 && src2_i[XLEN-1];
    a_mag   = a_neg ? (~src1_i + 1'b1) : src1_i;
    b_mag   = b_neg ? (~src2_i + 1'b1) : src2_i;
  end

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   rem_n;
  logic [XLEN-1:0]   quo_n;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opr_q} : {(XLEN+1){1'b0}});
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = (shifted >= {1'b0, opr_q});
    rem_n   = ge ? (shifted[XLEN-1:0] - opr_q) : shifted[XLEN-1:0];
    quo_n   = {lo_q[XLEN-2:0], ge};
    if (f3_q[2]) begin
      hi_n = rem_n;
      lo_n = quo_n;
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    q_fix  = neg_q ? (~lo_n + 1'b1) : lo_n;
    // Dividing by zero leaves |src1| as remainder, so the sign fix already yields src1.
    r_fix  = rneg_q ? (~hi_n + 1'b1) : hi_n;
    if (div0_q) begin
      q_fix = ONES_VAL;
    end
    if (ovf_q) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
    case (f3_q)
      F3_MUL:                      final_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             final_res = q_fix;
      default:                     final_res = r_fix;
    endcase
  end

  assign last_o = step_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      opr_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        f3_q   <= funct3_i;
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        div0_q <= st_div && (src2_i == '0);
        ovf_q  <= st_div && st_sgn1 && (src1_i == MIN_VAL) && (src2_i == ONES_VAL);
        opr_q  <= st_div ? b_mag : a_mag;
        hi_q   <= '0;
        lo_q   <= st_div ? a_mag : b_mag;
        cnt_q  <= '0;
      end else if (step_i) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + 1'b1;
        if (last_o) begin
          result_q <= final_res;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: rtl/alu_ctrl_md.sv
// Execute-stage ALU control decode plus sequencing of the iterative M-extension unit.
// stall_o holds the pipeline from the start cycle until the result cycle (exclusive).
module alu_ctrl_md
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit MD_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [3:0]      ALUCtrl_o,
  output logic            illegal_o,
  output logic            stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);

  logic [3:0] ctrl;
  logic       undec;
  logic       m_op;

  always_comb begin
    ctrl  = ALU_NOP;
    undec = 1'b0;
    m_op  = 1'b0;
    case (ALUOp_i)
      ALUOP_MEM: begin
        case (funct3_i)
          3'b000, 3'b011: ctrl = ALU_ADD;
          3'b001:         ctrl = ALU_SLL;
          3'b010:         ctrl = ALU_SLT;
          3'b100:         ctrl = ALU_XOR;
          3'b110:         ctrl = ALU_OR;
          3'b111:         ctrl = ALU_AND;
          default: begin
            if (funct7_i == F7_BASE)     ctrl = ALU_SRL;
            else if (funct7_i == F7_ALT) ctrl = ALU_SRA;
            else                         undec = 1'b1;
          end
        endcase
      end
      ALUOP_BR: ctrl = ALU_SUB;
      ALUOP_R: begin
        if (funct7_i == F7_BASE) begin
          case (funct3_i)
            3'b000:  ctrl = ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          if (funct3_i == 3'b000)      ctrl = ALU_SUB;
          else if (funct3_i == 3'b101) ctrl = ALU_SRA;
          else                         undec = 1'b1;
        end else if ((funct7_i == F7_MULDIV) && MD_EN) begin
          m_op = 1'b1;
        end else begin
          undec = 1'b1;
        end
      end
      default: undec = 1'b1;
    endcase
  end

  assign ALUCtrl_o = ctrl;
  assign illegal_o = valid_i && undec;

  md_state_e state_q;
  logic      start;
  logic      step;
  logic      last;

  assign start   = (state_q == MD_IDLE) && valid_i && m_op && !flush_i;
  assign step    = (state_q == MD_RUN) && !flush_i;
  assign stall_o = start || (state_q == MD_RUN);

  // DONE lasts exactly the cycle in which the unit's done pulse is high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (start) state_q <= MD_RUN;
        MD_RUN: begin
          if (flush_i)   state_q <= MD_IDLE;
          else if (last) state_q <= MD_DONE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .step_i   (step),
    .funct3_i (funct3_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .last_o   (last),
    .done_o   (md_done_o),
    .result_o (md_result_o)
  );

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Bench for alu_ctrl_md at XLEN=64: decode vector table, directed M-op corner cases, randomized M ops.
module tb_alu_ctrl_md;

  localparam int XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        flush;
  logic [1:0]  aluop;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [3:0]  alu_ctrl;
  logic        illegal;
  logic        stall;
  logic        md_done;
  logic [63:0] md_result;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_exp = '0;

  alu_ctrl_md #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .valid_i     (valid),
    .flush_i     (flush),
    .ALUOp_i     (aluop),
    .funct3_i    (f3),
    .funct7_i    (f7),
    .src1_i      (src1),
    .src2_i      (src2),
    .ALUCtrl_o   (alu_ctrl),
    .illegal_o   (illegal),
    .stall_o     (stall),
    .md_done_o   (md_done),
    .md_result_o (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decode reference: lookup tables indexed by funct3.
  function automatic void ref_dec(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                                  output logic [3:0] ctrl, output logic undec);
    logic [3:0] r_tab [8];
    logic [3:0] i_tab [8];
    r_tab = '{4'b0010, 4'b0100, 4'b0111, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    i_tab = '{4'b0010, 4'b0100, 4'b0111, 4'b0010, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    ctrl  = 4'b1111;
    undec = 1'b0;
    if (op == 2'b01) begin
      ctrl = 4'b0110;
    end else if (op == 2'b11) begin
      undec = 1'b1;
    end else if (op == 2'b00) begin
      if (fn3 != 3'b101)            ctrl = i_tab[fn3];
      else if (fn7 == 7'b0000000)   ctrl = 4'b0101;
      else if (fn7 == 7'b0100000)   ctrl = 4'b1000;
      else                          undec = 1'b1;
    end else begin
      if (fn7 == 7'b0000000)        ctrl = r_tab[fn3];
      else if (fn7 == 7'b0100000 && fn3 == 3'b000) ctrl = 4'b0110;
      else if (fn7 == 7'b0100000 && fn3 == 3'b101) ctrl = 4'b1000;
      else if (fn7 != 7'b0000001)   undec = 1'b1;
    end
  endfunction

  // M-op reference using wide and signed arithmetic directly.
  function automatic logic [63:0] ref_md(input logic [2:0] fn3, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic signed [63:0] sa, sb;
    logic signed [63:0] sq;
    sa = a;
    sb = b;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    case (fn3)
      3'd0: begin p = ea * eb; return p[63:0]; end
      3'd1: begin p = ea * eb; return p[127:64]; end
      3'd2: begin p = ea * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return MINV;
        sq = sa / sb;
        return sq;
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return 64'd0;
        sq = sa % sb;
        return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Launch an M op at posedge+1 and follow it to the done pulse, bounded.
  task automatic run_md(input logic [2:0] fn3, input logic [63:0] a, input logic [63:0] b,
                        input string nm, input bit chk_stall);
    logic [63:0] exp;
    int cyc;
    int stalls;
    bit seen;
    exp   = ref_md(fn3, a, b);
    valid = 1'b1;
    aluop = 2'b10;
    f7    = 7'b0000001;
    f3    = fn3;
    src1  = a;
    src2  = b;
    #1;
    stalls = stall ? 1 : 0;
    cyc    = 0;
    seen   = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (md_done) seen = 1'b1;
      else if (stall) stalls++;
    end
    chk({nm, "_latency"}, cyc, XLEN + 1);
    chk({nm, "_result"}, md_result, exp);
    if (chk_stall) begin
      chk({nm, "_stall_cycles"}, stalls, XLEN + 1);
      chk({nm, "_stall_at_done"}, stall, 1'b0);
    end
    last_exp = exp;
    valid = 1'b0;
    @(posedge clk);
    #1;
    if (chk_stall) chk({nm, "_done_pulse_width"}, md_done, 1'b0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return ONES;
      3: return MINV;
      4: return 64'($urandom_range(0, 100));
      5: return ~64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic [3:0] ctrl;
    logic       ill;
  } dec_vec_t;

  dec_vec_t tab [16];

  initial begin
    logic [3:0] rc;
    logic       ru;
    tab[0]  = '{1'b1, 2'b10, 3'b111, 7'h00, 4'b0000, 1'b0};
    tab[1]  = '{1'b1, 2'b10, 3'b000, 7'h20, 4'b0110, 1'b0};
    tab[2]  = '{1'b1, 2'b11, 3'b000, 7'h00, 4'b1111, 1'b1};
    tab[3]  = '{1'b0, 2'b11, 3'b000, 7'h00, 4'b1111, 1'b0};
    tab[4]  = '{1'b1, 2'b00, 3'b011, 7'h00, 4'b0010, 1'b0};
    tab[5]  = '{1'b1, 2'b00, 3'b010, 7'h00, 4'b0111, 1'b0};
    tab[6]  = '{1'b1, 2'b00, 3'b101, 7'h20, 4'b1000, 1'b0};
    tab[7]  = '{1'b1, 2'b00, 3'b101, 7'h00, 4'b0101, 1'b0};
    tab[8]  = '{1'b1, 2'b00, 3'b101, 7'h01, 4'b1111, 1'b1};
    tab[9]  = '{1'b1, 2'b01, 3'b100, 7'h7f, 4'b0110, 1'b0};
    tab[10] = '{1'b1, 2'b10, 3'b011, 7'h00, 4'b1001, 1'b0};
    tab[11] = '{1'b1, 2'b10, 3'b101, 7'h20, 4'b1000, 1'b0};
    tab[12] = '{1'b1, 2'b10, 3'b010, 7'h20, 4'b1111, 1'b1};
    tab[13] = '{1'b1, 2'b10, 3'b001, 7'h00, 4'b0100, 1'b0};
    tab[14] = '{1'b0, 2'b10, 3'b000, 7'h01, 4'b1111, 1'b0};
    tab[15] = '{1'b1, 2'b10, 3'b110, 7'h00, 4'b0001, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    aluop = 2'b00;
    f3    = 3'b000;
    f7    = 7'h00;
    src1  = '0;
    src2  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", md_done, 1'b0);
    chk("reset_result", md_result, 64'd0);
    chk("reset_stall", stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode vector table
    for (int i = 0; i < 16; i++) begin
      valid = tab[i].valid;
      aluop = tab[i].op;
      f3    = tab[i].fn3;
      f7    = tab[i].fn7;
      #1;
      chk($sformatf("dec%0d_ctrl", i), alu_ctrl, tab[i].ctrl);
      chk($sformatf("dec%0d_illegal", i), illegal, tab[i].ill);
      chk($sformatf("dec%0d_stall", i), stall, 1'b0);
    end
    valid = 1'b0;
    @(posedge clk);
    #1;

    // Random decode with flush held so no M op launches
    flush = 1'b1;
    for (int i = 0; i < 100; i++) begin
      valid = 1'($urandom_range(0, 1));
      aluop = 2'($urandom_range(0, 3));
      f3    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      #1;
      ref_dec(aluop, f3, f7, rc, ru);
      chk("rand_dec_ctrl", alu_ctrl, rc);
      chk("rand_dec_illegal", illegal, valid && ru);
    end
    flush = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;

    // Directed M ops
    run_md(3'd0, -64'sd3, 64'd7, "mul_neg3x7", 1'b1);
    run_md(3'd3, ONES, ONES, "mulhu_max", 1'b1);
    run_md(3'd1, ONES, ONES, "mulh_m1xm1", 1'b0);
    run_md(3'd4, -64'sd7, 64'd2, "div_m7_2", 1'b0);
    run_md(3'd6, -64'sd7, 64'd2, "rem_m7_2", 1'b0);
    run_md(3'd5, 64'd7, 64'd0, "divu_7_0", 1'b0);
    run_md(3'd6, 64'd5, 64'd0, "rem_5_0", 1'b0);
    run_md(3'd4, MINV, ONES, "div_ovf", 1'b0);
    run_md(3'd6, MINV, ONES, "rem_ovf", 1'b0);
    run_md(3'd4, -64'sd9, 64'd0, "div_neg_by0", 1'b0);

    // Flush while running at cnt=10, then a fresh MUL right away
    run_md(3'd7, 64'd100, 64'd7, "remu_pre_flush", 1'b0);
    valid = 1'b1;
    aluop = 2'b10;
    f7    = 7'h01;
    f3    = 3'd0;
    src1  = 64'd123;
    src2  = 64'd456;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid = 1'b0;
    #1;
    chk("flush_done", md_done, 1'b0);
    chk("flush_idle_stall", stall, 1'b0);
    chk("flush_result_held", md_result, last_exp);
    run_md(3'd0, 64'd6, 64'd7, "mul_after_flush", 1'b1);

    // Asynchronous reset while running at cnt=30
    valid = 1'b1;
    aluop = 2'b10;
    f7    = 7'h01;
    f3    = 3'd0;
    src1  = 64'd5;
    src2  = 64'd9;
    repeat (31) @(posedge clk);
    #1;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_done", md_done, 1'b0);
    chk("async_rst_result", md_result, 64'd0);
    chk("async_rst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_md(3'd4, 64'd100, 64'd7, "div_after_rst", 1'b1);

    // Randomized M ops against the reference model
    for (int i = 0; i < 30; i++) begin
      run_md(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $sformatf("rand_md%0d", i), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
